// File: rtl/mining_pkg.sv
// Shared definitions for the mining controller: flit layout, credit width,
// work-packet length and the controller state encoding.
package mining_pkg;

    localparam int FLIT_W      = 73;
    localparam int CREDIT_W    = 3;
    localparam int WORK_FLITS  = 6;

    localparam int FLIT_VALID  = 72;
    localparam int FLIT_TAIL   = 71;
    localparam int DEST_LSB    = 66;
    localparam int DEST_W      = 5;
    localparam int VC_LSB      = 64;
    localparam int VC_W        = 2;
    localparam int DATA_W      = 64;
    localparam int NONCE_W     = 32;
    localparam int CLK_CNT_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_e;

    // Assemble a valid flit from its fields.
    function automatic logic [FLIT_W-1:0] make_flit(
        input logic              tail,
        input logic [DEST_W-1:0] dest,
        input logic [VC_W-1:0]   vc,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, tail, dest, vc, data};
    endfunction

endpackage

// File: rtl/mining_controller_credit_counter.sv
// VC0 send-credit counter. Starts full, saturates at CREDIT_INIT and gates
// flit issue while no credit is available.
module credit_counter #(
    parameter int CREDIT_INIT = 16
) (
    input  logic sys_clk_i,
    input  logic rst_i,
    input  logic send_req_i,
    input  logic credit_in_i,
    output logic fire_o
);

    localparam int CW = $clog2(CREDIT_INIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign fire_o = send_req_i && (cnt_q != '0);

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({fire_o, credit_in_i})
            2'b10:   cnt_d = cnt_q - 1'b1;
            2'b01:   if (cnt_q < CW'(CREDIT_INIT)) cnt_d = cnt_q + 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter register, refilled on reset.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) cnt_q <= CW'(CREDIT_INIT);
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mining_controller.sv
// Work distribution / result collection master on network port 0.
// Optional feature macro: CTRL_CYCLE_COUNTER_EN enables the Clk_cnt cycle
// counter; without it Clk_cnt is constant zero.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | one cycle after reset release
// ST_SEND | issuing work packets, PE 1..NUM_PE, flit 0..5, credit gated
// ST_WAIT | all work sent, waiting for the first result flit
// ST_DONE | nonce latched, further received flits drained and ignored
module mining_controller
    import mining_pkg::*;
#(
    parameter int           NUM_PE      = 8,
    parameter int           CREDIT_INIT = 16,
    parameter logic [255:0] MIDSTATE    = 256'h0,
    parameter logic [95:0]  DATA_TAIL   = 96'h0,
    parameter logic [31:0]  NONCE_STEP  = 32'h2000_0000
) (
    input  logic                 sys_clk,
    input  logic                 nreset,
    output logic [FLIT_W-1:0]    putFlit,
    output logic                 EN_putFlit,
    input  logic [CREDIT_W-1:0]  getCredits,
    output logic                 EN_getFlit,
    input  logic [FLIT_W-1:0]    getFlit,
    output logic                 EN_putCredits,
    output logic [CREDIT_W-1:0]  putCredits,
    output logic                 done,
    output logic [NONCE_W-1:0]   nonce,
    output logic [CLK_CNT_W-1:0] Clk_cnt
);

    ctrl_state_e          state_q;
    logic [DEST_W-1:0]    pe_q;
    logic [2:0]           idx_q;
    logic [FLIT_W-1:0]    put_flit_q;
    logic                 en_put_flit_q;
    logic                 en_get_flit_q;
    logic                 en_put_credits_q;
    logic [CREDIT_W-1:0]  put_credits_q;
    logic                 done_q;
    logic [NONCE_W-1:0]   nonce_q;

    logic                 send_req;
    logic                 fire;
    logic                 rx_valid;
    logic                 last_flit;
    logic [DATA_W-1:0]    flit_data;
    logic [NONCE_W-1:0]   nonce_base;
    logic [NONCE_W-1:0]   pe_ext;

    // Sender id and the remaining result-flit fields carry nothing we use.
    logic unused_rx;
    assign unused_rx = ^{getFlit[FLIT_TAIL:DEST_LSB], getFlit[DATA_W-1:NONCE_W],
                         getCredits[VC_W-1:0]};

    assign send_req  = (state_q == ST_SEND);
    assign rx_valid  = en_get_flit_q && getFlit[FLIT_VALID];
    assign last_flit = (idx_q == 3'(WORK_FLITS - 1));
    assign pe_ext    = {{(NONCE_W - DEST_W){1'b0}}, pe_q};
    assign nonce_base = (pe_ext - 32'd1) * NONCE_STEP;

    credit_counter #(
        .CREDIT_INIT (CREDIT_INIT)
    ) u_credit_counter (
        .sys_clk_i   (sys_clk),
        .rst_i       (nreset),
        .send_req_i  (send_req),
        .credit_in_i (getCredits[CREDIT_W-1]),
        .fire_o      (fire)
    );

    // Payload of the current work flit; the last flit carries the PE's nonce start.
    always_comb begin
        flit_data = MIDSTATE[255:192];
        case (idx_q)
            3'd0:    flit_data = MIDSTATE[255:192];
            3'd1:    flit_data = MIDSTATE[191:128];
            3'd2:    flit_data = MIDSTATE[127:64];
            3'd3:    flit_data = MIDSTATE[63:0];
            3'd4:    flit_data = DATA_TAIL[95:32];
            default: flit_data = {DATA_TAIL[31:0], nonce_base};
        endcase
    end

    // Controller FSM with registered send, receive and result outputs.
    always_ff @(posedge sys_clk) begin
        if (nreset) begin
            state_q          <= ST_IDLE;
            pe_q             <= DEST_W'(1);
            idx_q            <= '0;
            put_flit_q       <= '0;
            en_put_flit_q    <= 1'b0;
            en_get_flit_q    <= 1'b0;
            en_put_credits_q <= 1'b0;
            put_credits_q    <= '0;
            done_q           <= 1'b0;
            nonce_q          <= '0;
        end else begin
            en_get_flit_q    <= 1'b1;
            en_put_flit_q    <= fire;
            put_flit_q       <= fire ? make_flit(last_flit, pe_q, 2'b00, flit_data) : '0;
            en_put_credits_q <= rx_valid;
            put_credits_q    <= rx_valid ? {1'b1, getFlit[VC_LSB+:VC_W]} : '0;
            case (state_q)
                ST_IDLE: state_q <= ST_SEND;
                ST_SEND: begin
                    if (fire) begin
                        if (last_flit) begin
                            idx_q <= '0;
                            if (pe_q == DEST_W'(NUM_PE)) state_q <= ST_WAIT;
                            else                         pe_q    <= pe_q + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rx_valid) begin
                        nonce_q <= getFlit[NONCE_W-1:0];
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_DONE;
            endcase
        end
    end

`ifdef CTRL_CYCLE_COUNTER_EN
    logic [CLK_CNT_W-1:0] clk_cnt_q;

    // Run from reset release; the capture edge is the last one counted.
    always_ff @(posedge sys_clk) begin
        if (nreset)                 clk_cnt_q <= '0;
        else if (state_q != ST_DONE) clk_cnt_q <= clk_cnt_q + 1'b1;
    end

    assign Clk_cnt = clk_cnt_q;
`else
    assign Clk_cnt = '0;
`endif

    assign putFlit       = put_flit_q;
    assign EN_putFlit    = en_put_flit_q;
    assign EN_getFlit    = en_get_flit_q;
    assign EN_putCredits = en_put_credits_q;
    assign putCredits    = put_credits_q;
    assign done          = done_q;
    assign nonce         = nonce_q;

endmodule

// File: tb/tb_mining_controller.sv
// Directed self-checking bench for mining_controller.
module tb_mining_controller;

    localparam logic [255:0] MS = 256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444;
    localparam logic [95:0]  DT = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;

    logic         clk = 1'b0;
    logic         nreset = 1'b1;
    logic [72:0]  putFlit;
    logic         EN_putFlit;
    logic [2:0]   getCredits = 3'b000;
    logic         EN_getFlit;
    logic [72:0]  getFlit = '0;
    logic         EN_putCredits;
    logic [2:0]   putCredits;
    logic         done;
    logic [31:0]  nonce;
    logic [63:0]  Clk_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int edges   = 0;
    logic [63:0] cnt_snap;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nreset) edges <= 0;
        else        edges <= edges + 1;
    end

    mining_controller #(
        .NUM_PE      (8),
        .CREDIT_INIT (16),
        .MIDSTATE    (MS),
        .DATA_TAIL   (DT),
        .NONCE_STEP  (32'h2000_0000)
    ) dut (
        .sys_clk       (clk),
        .nreset        (nreset),
        .putFlit       (putFlit),
        .EN_putFlit    (EN_putFlit),
        .getCredits    (getCredits),
        .EN_getFlit    (EN_getFlit),
        .getFlit       (getFlit),
        .EN_putCredits (EN_putCredits),
        .putCredits    (putCredits),
        .done          (done),
        .nonce         (nonce),
        .Clk_cnt       (Clk_cnt)
    );

    // Expected k-th flit of the whole work stream (k = 0..47).
    function automatic logic [72:0] exp_flit(input int k);
        int pe;
        int i;
        logic [63:0] d;
        logic [31:0] nb;
        pe = k / 6 + 1;
        i  = k % 6;
        nb = 32'(pe - 1) * 32'h2000_0000;
        case (i)
            0:       d = MS[255:192];
            1:       d = MS[191:128];
            2:       d = MS[127:64];
            3:       d = MS[63:0];
            4:       d = DT[95:32];
            default: d = {DT[31:0], nb};
        endcase
        return {1'b1, (i == 5), 5'(pe), 2'b00, d};
    endfunction

    task automatic apply_reset();
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        getCredits = 3'b000;
        getFlit = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (EN_putFlit !== 1'b0 || putFlit !== 73'h0) begin
            n_fail++; $display("FAIL reset_put: EN=%b flit=%h required 0/0", EN_putFlit, putFlit);
        end
        n_tests++;
        if (EN_getFlit !== 1'b0 || EN_putCredits !== 1'b0 || putCredits !== 3'b000) begin
            n_fail++; $display("FAIL reset_rx: EN_get=%b EN_pc=%b pc=%b required 0", EN_getFlit, EN_putCredits, putCredits);
        end
        n_tests++;
        if (done !== 1'b0 || nonce !== 32'h0 || Clk_cnt !== 64'h0) begin
            n_fail++; $display("FAIL reset_result: done=%b nonce=%h cnt=%0d required 0", done, nonce, Clk_cnt);
        end
    endtask

    task automatic test_stream();
        int bad;
        getCredits = 3'b100;
        apply_reset();
        bad = 0;
        for (int c = 1; c <= 52; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                n_tests++;
                if (EN_putFlit !== 1'b0 || EN_getFlit !== 1'b1) begin
                    n_fail++; $display("FAIL stream_first_cycle: EN_put=%b EN_get=%b required 0/1", EN_putFlit, EN_getFlit);
                end
            end else if (c <= 49) begin
                n_tests++;
                if (EN_putFlit !== 1'b1 || putFlit !== exp_flit(c - 2)) begin
                    n_fail++; $display("FAIL stream_flit%0d: EN=%b flit=%h required 1/%h", c - 2, EN_putFlit, putFlit, exp_flit(c - 2));
                end
                if (c == 19) begin
                    n_tests++;
                    if (putFlit[31:0] !== 32'h4000_0000 || putFlit[71] !== 1'b1 || putFlit[70:66] !== 5'd3) begin
                        n_fail++; $display("FAIL stream_pe3_tail: nonce=%h tail=%b dest=%0d required 40000000/1/3", putFlit[31:0], putFlit[71], putFlit[70:66]);
                    end
                end
            end else begin
                n_tests++;
                if (EN_putFlit !== 1'b0) begin
                    n_fail++; $display("FAIL stream_after_last: EN=%b required 0", EN_putFlit);
                end
            end
        end
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL wait_not_done: done=%b required 0", done);
        end
    endtask

    task automatic test_result();
        logic [63:0] exp_cnt;
        getFlit = {1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_0003, 32'hDEAD_BEEF};
        @(posedge clk);
        #1;
        getFlit = '0;
`ifdef CTRL_CYCLE_COUNTER_EN
        exp_cnt = 64'(edges);
`else
        exp_cnt = 64'h0;
`endif
        n_tests++;
        if (done !== 1'b1 || nonce !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL result_latch: done=%b nonce=%h required 1/deadbeef", done, nonce);
        end
        n_tests++;
        if (EN_putCredits !== 1'b1 || putCredits !== 3'b100) begin
            n_fail++; $display("FAIL result_credit: EN=%b pc=%b required 1/100", EN_putCredits, putCredits);
        end
        n_tests++;
        if (Clk_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL result_clk_cnt: cnt=%0d required %0d", Clk_cnt, exp_cnt);
        end
        cnt_snap = Clk_cnt;
        @(posedge clk);
        #1;
        n_tests++;
        if (EN_putCredits !== 1'b0) begin
            n_fail++; $display("FAIL result_credit_pulse: EN=%b required 0", EN_putCredits);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (Clk_cnt !== exp_cnt || done !== 1'b1) begin
            n_fail++; $display("FAIL clk_cnt_frozen: cnt=%0d done=%b required %0d/1", Clk_cnt, done, exp_cnt);
        end
    endtask

    task automatic test_after_done();
        getFlit = {1'b1, 1'b1, 5'd0, 2'b10, 32'h0000_0005, 32'h1234_5678};
        @(posedge clk);
        #1;
        getFlit = '0;
        n_tests++;
        if (nonce !== 32'hDEAD_BEEF || done !== 1'b1) begin
            n_fail++; $display("FAIL done_drain_nonce: nonce=%h done=%b required deadbeef/1", nonce, done);
        end
        n_tests++;
        if (EN_putCredits !== 1'b1 || putCredits !== 3'b110) begin
            n_fail++; $display("FAIL done_drain_credit: EN=%b pc=%b required 1/110", EN_putCredits, putCredits);
        end
        n_tests++;
        if (Clk_cnt !== cnt_snap) begin
            n_fail++; $display("FAIL done_drain_cnt: cnt=%0d required %0d", Clk_cnt, cnt_snap);
        end
    endtask

    task automatic test_reset_mid_send();
        getCredits = 3'b100;
        apply_reset();
        repeat (10) @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (EN_putFlit !== 1'b0 || putFlit !== 73'h0 || EN_getFlit !== 1'b0) begin
            n_fail++; $display("FAIL midreset_put: EN=%b flit=%h EN_get=%b required 0", EN_putFlit, putFlit, EN_getFlit);
        end
        n_tests++;
        if (done !== 1'b0 || nonce !== 32'h0 || Clk_cnt !== 64'h0 || EN_putCredits !== 1'b0 || putCredits !== 3'b000) begin
            n_fail++; $display("FAIL midreset_result: done=%b nonce=%h cnt=%0d EN_pc=%b pc=%b required 0", done, nonce, Clk_cnt, EN_putCredits, putCredits);
        end
        nreset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (EN_putFlit !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: EN=%b required 0", EN_putFlit);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (EN_putFlit !== 1'b1 || putFlit !== exp_flit(k)) begin
                n_fail++; $display("FAIL midreset_restart%0d: EN=%b flit=%h required 1/%h", k, EN_putFlit, putFlit, exp_flit(k));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [72:0] last;
        getCredits = 3'b100;
        apply_reset();
        @(posedge clk);
        #1 getCredits = 3'b000;
        n = 0;
        last = '0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (EN_putFlit) begin n++; last = putFlit; end
        end
        n_tests++;
        if (n != 16 || last !== exp_flit(15)) begin
            n_fail++; $display("FAIL bp_initial: flits=%0d last=%h required 16/%h", n, last, exp_flit(15));
        end
        getCredits = 3'b100;
        n = 0;
        @(posedge clk);
        #1 getCredits = 3'b000;
        if (EN_putFlit) begin n++; last = putFlit; end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (EN_putFlit) begin n++; last = putFlit; end
        end
        n_tests++;
        if (n != 1 || last !== exp_flit(16)) begin
            n_fail++; $display("FAIL bp_one_credit: flits=%0d last=%h required 1/%h", n, last, exp_flit(16));
        end
        getCredits = 3'b100;
        n = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (EN_putFlit) begin n++; last = putFlit; end
        end
        getCredits = 3'b000;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (EN_putFlit) begin n++; last = putFlit; end
        end
        n_tests++;
        if (n != 2 || last !== exp_flit(18)) begin
            n_fail++; $display("FAIL bp_overlap: flits=%0d last=%h required 2/%h", n, last, exp_flit(18));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_result();
        test_after_done();
        test_reset_mid_send();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
